// File: rtl/cte_yuv_enc_if.sv
// Pixel-in / word-out bundle for cte_yuv_enc. The master drives pixels and
// the slave (encoder) returns busy and the output word stream.
interface cte_yuv_enc_if #(
  parameter int DW = 8
);
  logic            op_mode;
  logic            in_en;
  logic [3*DW-1:0] rgb_in;
  logic            busy;
  logic            out_valid;
  logic [DW-1:0]   yuv_out;

  modport master (
    output op_mode, in_en, rgb_in,
    input  busy, out_valid, yuv_out
  );

  modport slave (
    input  op_mode, in_en, rgb_in,
    output busy, out_valid, yuv_out
  );
endinterface

// File: rtl/cte_yuv_enc.sv
// RGB to YUV 4:4:4 / 4:2:2 encoder: two-stage arithmetic pipeline feeding a
// multi-word-write output FIFO, throttled by a pending-word counter.
module cte_yuv_enc #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  cte_yuv_enc_if.slave bus
);
  localparam int SW = DW + 16;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic signed [SW-1:0] KYR = SW'(1225);
  localparam logic signed [SW-1:0] KYG = SW'(2404);
  localparam logic signed [SW-1:0] KYB = SW'(467);
  localparam logic signed [SW-1:0] KUR = SW'(-692);
  localparam logic signed [SW-1:0] KUG = SW'(-1356);
  localparam logic signed [SW-1:0] KUB = SW'(2048);
  localparam logic signed [SW-1:0] KVR = SW'(2048);
  localparam logic signed [SW-1:0] KVG = SW'(-1716);
  localparam logic signed [SW-1:0] KVB = SW'(-332);
  localparam logic signed [SW-1:0] HALF12 = SW'(2048);
  localparam logic signed [SW-1:0] HALF13 = SW'(4096);
  localparam logic signed [SW-1:0] ZERO   = '0;
  localparam logic signed [SW-1:0] YMAX   = SW'((1 << DW) - 1);
  localparam logic signed [SW-1:0] SMAX   = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN   = SW'(-(1 << (DW - 1)));
  localparam logic [CW-1:0]        BUSY_TH = CW'(DEPTH - 4);

  function automatic logic signed [SW-1:0] mac(input logic [3*DW-1:0] px,
      input logic signed [SW-1:0] kr, input logic signed [SW-1:0] kg,
      input logic signed [SW-1:0] kb);
    logic signed [SW-1:0] r, g, b;
    r = signed'({{(SW-DW){1'b0}}, px[3*DW-1:2*DW]});
    g = signed'({{(SW-DW){1'b0}}, px[2*DW-1:DW]});
    b = signed'({{(SW-DW){1'b0}}, px[DW-1:0]});
    return r * kr + g * kg + b * kb;
  endfunction

  function automatic logic [DW-1:0] sat_y(input logic signed [SW-1:0] v);
    if (v < ZERO) return '0;
    if (v > YMAX) return '1;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_c(input logic signed [SW-1:0] v);
    if (v < SMIN) return {1'b1, {(DW-1){1'b0}}};
    if (v > SMAX) return {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p, input logic [2:0] k);
    logic [PW-1:0] s;
    s = {1'b0, p} + PW'(k);
    if (s >= PW'(DEPTH)) s = s - PW'(DEPTH);
    return s[AW-1:0];
  endfunction

  logic                 phase_q;
  logic [3*DW-1:0]      p0_q;
  logic                 s1_valid_q, s1_mode_q;
  logic [3*DW-1:0]      s1_pix_q, s1_p0_q;
  logic                 s2_valid_q, s2_mode_q;
  logic signed [SW-1:0] s2_ya_q, s2_yb_q, s2_u_q, s2_v_q;
  logic signed [SW-1:0] ya_d, yb_d, u_d, v_d;
  logic [DW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]        wr_pos [4];
  logic [CW-1:0]        cnt_q, cnt_d, pend_q, pend_d, pend_add;
  logic                 out_valid_q;
  logic [DW-1:0]        yuv_out_q;
  logic [DW-1:0]        w_word [4];
  logic [2:0]           w_num;
  logic                 busy, accept, pop;

  assign busy          = pend_q > BUSY_TH;
  assign accept        = bus.in_en && !busy;
  assign pop           = cnt_q != '0;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_q;
  assign bus.yuv_out   = yuv_out_q;

  always_comb begin
    pend_add = '0;
    if (accept) begin
      if (bus.op_mode)  pend_add = CW'(3);
      else if (phase_q) pend_add = CW'(4);
    end
    pend_d = pend_q + pend_add - CW'(pop);
    cnt_d  = cnt_q + (s2_valid_q ? CW'(w_num) : '0) - CW'(pop);
  end

  // A 4:2:2 pair keeps full-precision chroma sums; rounding happens once.
  always_comb begin
    if (s1_mode_q) begin
      ya_d = mac(s1_pix_q, KYR, KYG, KYB);
      yb_d = '0;
      u_d  = mac(s1_pix_q, KUR, KUG, KUB);
      v_d  = mac(s1_pix_q, KVR, KVG, KVB);
    end else begin
      ya_d = mac(s1_p0_q, KYR, KYG, KYB);
      yb_d = mac(s1_pix_q, KYR, KYG, KYB);
      u_d  = mac(s1_p0_q, KUR, KUG, KUB) + mac(s1_pix_q, KUR, KUG, KUB);
      v_d  = mac(s1_p0_q, KVR, KVG, KVB) + mac(s1_pix_q, KVR, KVG, KVB);
    end
  end

  always_comb begin
    w_word[1] = sat_y((s2_ya_q + HALF12) >>> 12);
    w_word[3] = sat_y((s2_yb_q + HALF12) >>> 12);
    if (s2_mode_q) begin
      w_word[0] = sat_c((s2_u_q + HALF12) >>> 12);
      w_word[2] = sat_c((s2_v_q + HALF12) >>> 12);
      w_num     = 3'd3;
    end else begin
      w_word[0] = sat_c((s2_u_q + HALF13) >>> 13);
      w_word[2] = sat_c((s2_v_q + HALF13) >>> 13);
      w_num     = 3'd4;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_wpos
    assign wr_pos[gi] = wrap(wr_ptr_q, 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (s2_valid_q) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < w_num) mem_q[wr_pos[k]] <= w_word[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= 1'b0;
      p0_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_pix_q    <= '0;
      s1_p0_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_ya_q     <= '0;
      s2_yb_q     <= '0;
      s2_u_q      <= '0;
      s2_v_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      yuv_out_q   <= '0;
    end else begin
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= 1'b0;
      // A 4:4:4 pixel arriving with P0 held drops P0 and clears the phase.
      if (accept) begin
        if (bus.op_mode || phase_q) begin
          s1_valid_q <= 1'b1;
          s1_mode_q  <= bus.op_mode;
          s1_pix_q   <= bus.rgb_in;
          s1_p0_q    <= p0_q;
          phase_q    <= 1'b0;
        end else begin
          p0_q    <= bus.rgb_in;
          phase_q <= 1'b1;
        end
      end
      s2_valid_q <= s1_valid_q;
      s2_mode_q  <= s1_mode_q;
      s2_ya_q    <= ya_d;
      s2_yb_q    <= yb_d;
      s2_u_q     <= u_d;
      s2_v_q     <= v_d;
      if (s2_valid_q) wr_ptr_q <= wrap(wr_ptr_q, w_num);
      out_valid_q <= pop;
      if (pop) begin
        yuv_out_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= wrap(rd_ptr_q, 3'd1);
      end
    end
  end
endmodule

// File: doc/cte_yuv_enc.md
CTE_YUV_ENC -- requirements
Module: cte_yuv_enc

Interface
REQ-001 SHALL have parameter DW, default 8, bits per colour component (legal range 6..12).
REQ-002 SHALL have parameter DEPTH, default 8, output FIFO depth in words (legal range 4..32).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_mode  input  1  format of the accepted pixel: 0 = YUV 4:2:2, 1 = YUV 4:4:4.
REQ-006 SHALL have port in_en  input  1  pixel-valid strobe.
REQ-007 SHALL have port rgb_in  input  3*DW  pixel, R in [3DW-1:2DW], G in [2DW-1:DW], B in [DW-1:0], unsigned.
REQ-008 SHALL have port busy  output  1  high means no pixel is accepted this cycle.
REQ-009 SHALL have port out_valid  output  1  yuv_out holds a valid word this cycle.
REQ-010 SHALL have port yuv_out  output  DW  output component: Y unsigned, U/V two's complement.

Function
REQ-011 SHALL accept a pixel at a rising edge where in_en=1 and busy=0, and SHALL sample op_mode with it; other in_en cycles are ignored, with no error.
REQ-012 SHALL compute with 12-bit fixed-point coefficients. Y = 1225R + 2404G + 467B. U = -692R - 1356G + 2048B. V = 2048R - 1716G - 332B.
REQ-013 SHALL round by adding 2048 and arithmetic-shifting right by 12 (floor).
REQ-014 SHALL saturate Y to [0, 2^DW-1] and U/V to [-2^(DW-1), 2^(DW-1)-1].
REQ-015 Mode 1 SHALL emit 3 words per pixel, in order U, Y, V.
REQ-016 Mode 0 SHALL pair consecutive accepted pixels P0, P1 and emit 4 words U, Y0, V, Y1 after P1. U and V use the unrounded sums of both pixels, with 4096 added and an arithmetic shift right by 13, then saturation.
REQ-017 SHALL hold pair state in a phase flag: 0 = expecting P0, 1 = P0 held.
REQ-018 If a mode-1 pixel is accepted while phase=1, the held P0 SHALL be discarded without output, phase SHALL clear, and the mode-1 pixel SHALL be processed normally.
REQ-019 SHALL use a 2-stage pipeline: edge t accepts, edge t+1 registers the sums, edge t+2 writes all 3 or 4 words into the FIFO in one cycle.
REQ-020 SHALL register out_valid/yuv_out from the FIFO head, so with an empty FIFO the first word is valid after edge t+3. Words then drain one per cycle with no gaps while the FIFO is non-empty.
REQ-021 SHALL keep a pending counter pend = words in the FIFO + words committed by accepted, unwritten pixels.
REQ-022 pend SHALL increase at the accept edge by 3 (mode 1), 4 (mode 0, P1) or 0 (mode 0, P0), and SHALL decrease by 1 on every edge that loads a word into yuv_out; both may occur on the same edge.
REQ-023 busy SHALL equal (pend > DEPTH-4), decoded from registers only, so the FIFO never overflows and no word is lost.
REQ-024 out_valid SHALL be 0 and yuv_out SHALL hold its last value when no word is presented.
REQ-025 Output has no backpressure; the consumer SHALL take every out_valid word.

Reset
REQ-026 reset low SHALL immediately force busy=0, out_valid=0, yuv_out=0, pend=0, phase=0, an empty FIFO and cleared pipeline registers, independent of clk.
REQ-027 After reset rises, no word from before reset SHALL ever appear; the first accept is allowed on the first edge with reset high.

Verification
REQ-028 Reset asserted mid-stream with words queued -> outputs zero at once; after release, only words from new pixels appear.
REQ-029 DW=8, mode 1, rgb_in=FFFFFF -> words 00, FF, 00 valid at accept+3, +4, +5.
REQ-030 DW=8, mode 1, rgb_in=FF0000 -> words D5 (U=-43), 4C (Y=76), 7F (V=128 saturated to 127).
REQ-031 DW=8, mode 0, pixels 000000 then FFFFFF -> words 00, 00, 00, FF; no output after P0 alone.
REQ-032 DW=8, DEPTH=8, in_en held high, mode 1 -> one accept per 3 cycles in steady state, out_valid continuously high after the first word, and word count = 3 x accepts.
REQ-033 Mode 0 P0 accepted, then a mode-1 pixel FFFFFF -> only 00, FF, 00 is emitted, and the next mode-0 pixel is treated as P0.
